bist_controller: RTL and testbench

- On-chip BIST responder that answers the bist_start / bist_end / pass_nfail interface driven by the test environment.
- On a start request it resets and exercises the circuit under test (CUT) with LFSR pseudo-random patterns. It compacts the CUT responses in a MISR and compares the final signature against a golden value.
- Sits inside the top level between the external BIST pins and the CUT input mux.

---
 rtl/bist_controller_pkg.sv | 21 ++
 rtl/bist_misr.sv | 53 +++++
 rtl/bist_controller.sv | 161 ++++++++++++++++
 tb/tb_bist_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_controller_pkg.sv
// bist_controller_pkg
// Shared definitions for the BIST responder: FSM state encoding, default
// LFSR / MISR constants and the pattern counter width.
// No ports; imported by bist_controller and bist_misr.
package bist_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT    = 2'd1,
        RUN     = 2'd2,
        COMPARE = 2'd3
    } bist_state_e;

    localparam logic [7:0]  DEFAULT_LFSR_TAPS = 8'hB8;
    localparam logic [7:0]  DEFAULT_LFSR_SEED = 8'h01;
    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

    // Wide enough for the largest supported pattern count (255).
    localparam int COUNT_W = 8;

endpackage

// File: rtl/bist_misr.sv
// bist_misr
// Multiple-input signature register that folds the CUT response into a
// running signature, one word per enabled clock.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset (signature -> 0)
//   clear     in   synchronous clear to 0, has priority over enable
//   enable    in   compact data_in into the signature this edge
//   data_in   in   IN_W-bit CUT response, zero-extended to MISR_W
//   signature out  current signature register contents
module bist_misr
    import bist_controller_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = DEFAULT_MISR_POLY,
    parameter int                IN_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [IN_W-1:0]   data_in,
    output logic [MISR_W-1:0] signature
);

    logic [MISR_W-1:0] signature_q;
    logic [MISR_W-1:0] signature_d;

    // Shift left, fold the polynomial back in when the MSB falls out, then
    // mix in the response word on the low bits.
    always_comb begin
        signature_d = signature_q;
        if (clear) begin
            signature_d = '0;
        end else if (enable) begin
            signature_d = {signature_q[MISR_W-2:0], 1'b0}
                        ^ (signature_q[MISR_W-1] ? MISR_POLY : '0)
                        ^ MISR_W'(data_in);
        end
    end

    // Signature register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signature_q <= '0;
        end else begin
            signature_q <= signature_d;
        end
    end

    assign signature = signature_q;

endmodule

// File: rtl/bist_controller.sv
// bist_controller
// BIST responder: on a rising edge of bist_start it pulses the CUT reset,
// drives N_PATTERNS LFSR patterns into the CUT, compacts the responses in a
// MISR and reports whether the final signature equals GOLDEN_SIG.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   bist_start  in   start request, rising edge triggers one run
//   cut_in      out  test pattern (LFSR low bits) during RUN, else 0
//   cut_out     in   CUT response, compacted during RUN
//   test_mode   out  high in INIT and RUN, selects cut_in onto the CUT
//   cut_reset   out  one-cycle CUT reset pulse during INIT
//   bist_end    out  run complete, result valid
//   pass_nfail  out  1 = signature matched (meaningful while bist_end=1)
module bist_controller
    import bist_controller_pkg::*;
#(
    parameter int                N_PATTERNS = 8,
    parameter int                CUT_IN_W   = 2,
    parameter int                CUT_OUT_W  = 2,
    parameter int                LFSR_W     = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS  = DEFAULT_LFSR_TAPS,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = DEFAULT_LFSR_SEED,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = DEFAULT_MISR_POLY,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bist_start,
    output logic [CUT_IN_W-1:0]  cut_in,
    input  logic [CUT_OUT_W-1:0] cut_out,
    output logic                 test_mode,
    output logic                 cut_reset,
    output logic                 bist_end,
    output logic                 pass_nfail
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(N_PATTERNS - 1);

    bist_state_e        state_q;
    bist_state_e        state_d;
    logic               start_q;
    logic               armed_q;
    logic               trigger;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [LFSR_W-1:0]  lfsr_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               cut_reset_q;
    logic               cut_reset_d;
    logic               bist_end_q;
    logic               bist_end_d;
    logic               pass_q;
    logic               pass_d;
    logic               misr_clear;
    logic               misr_enable;
    logic [MISR_W-1:0]  signature;

    // armed_q stays low for the first edge after reset so that a bist_start
    // level held through reset is only sampled, never seen as a rising edge.
    assign trigger = bist_start & ~start_q & armed_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: bist_start is only looked at in IDLE, so a run in
    // progress always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (count_q == LAST_COUNT) state_d = COMPARE;
            COMPARE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from registers only; cut_in is forced to 0 outside
    // RUN so every output reads 0 while in reset.
    always_comb begin
        test_mode = (state_q == INIT) || (state_q == RUN);
        cut_in    = (state_q == RUN) ? lfsr_q[CUT_IN_W-1:0] : '0;
    end

    // Datapath next state. Everything is re-initialised on the edge that
    // enters INIT, so the old result is withdrawn for the whole new run and
    // RUN starts from the seed with a clean MISR.
    always_comb begin
        lfsr_d      = lfsr_q;
        count_d     = count_q;
        bist_end_d  = bist_end_q;
        pass_d      = pass_q;
        cut_reset_d = 1'b0;
        misr_clear  = 1'b0;
        misr_enable = 1'b0;
        if (state_d == INIT) begin
            cut_reset_d = 1'b1;
            lfsr_d      = LFSR_SEED;
            count_d     = '0;
            misr_clear  = 1'b1;
            bist_end_d  = 1'b0;
            pass_d      = 1'b0;
        end
        if (state_q == RUN) begin
            lfsr_d      = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            count_d     = count_q + COUNT_W'(1);
            misr_enable = 1'b1;
        end
        if (state_q == COMPARE) begin
            bist_end_d = 1'b1;
            pass_d     = (signature == GOLDEN_SIG);
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            count_q     <= '0;
            cut_reset_q <= 1'b0;
            bist_end_q  <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            start_q     <= bist_start;
            armed_q     <= 1'b1;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            cut_reset_q <= cut_reset_d;
            bist_end_q  <= bist_end_d;
            pass_q      <= pass_d;
        end
    end

    bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY),
        .IN_W      (CUT_OUT_W)
    ) u_misr (
        .clk       (clk),
        .reset     (reset),
        .clear     (misr_clear),
        .enable    (misr_enable),
        .data_in   (cut_out),
        .signature (signature)
    );

    assign cut_reset  = cut_reset_q;
    assign bist_end   = bist_end_q;
    assign pass_nfail = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller
// Drives bist_controller with a small behavioural CUT (with selectable
// faults) and compares pattern sequence, pulse widths, latency and verdict
// against an integer reference model of the LFSR / MISR rules.
module tb_bist_controller;

    localparam int N1 = 8;
    localparam int N2 = 40;

    // Parity of the low 8 bits of v.
    function automatic int parity8(input int v);
        int p;
        p = 0;
        for (int b = 0; b < 8; b++) p = p ^ ((v >> b) & 1);
        return p;
    endfunction

    // Behavioural CUT: out[1] = in1 xor in0, out[0] = in1 or in0.
    // fault 1: out[0] stuck at 0, 2: out[1] stuck at 1, 3: out[0] flips on in=3.
    function automatic int cutModel(input int in, input int fault);
        int a;
        int b;
        int o;
        a = in & 1;
        b = (in >> 1) & 1;
        o = ((a ^ b) << 1) | (a | b);
        if (fault == 1) o = o & 2;
        else if (fault == 2) o = o | 2;
        else if (fault == 3 && in == 3) o = o ^ 1;
        return o;
    endfunction

    // Reference signature after n patterns: LFSR from seed 1 with taps 0xB8,
    // MISR doubling mod 2^16 with 0x1021 folded in on overflow.
    function automatic logic [15:0] modelSig(input int n, input int fault);
        int lfsr;
        int sig;
        lfsr = 1;
        sig  = 0;
        for (int i = 0; i < n; i++) begin
            sig = sig * 2;
            if (sig >= 65536) sig = (sig - 65536) ^ 4129;
            sig  = sig ^ cutModel(lfsr % 4, fault);
            lfsr = ((lfsr * 2) % 256) + parity8(lfsr & 184);
        end
        return 16'(sig);
    endfunction

    localparam logic [15:0] GOLD1 = modelSig(N1, 0);
    localparam logic [15:0] GOLD2 = modelSig(N2, 0);

    logic       clk = 1'b0;
    logic       reset;
    logic       bistStart;
    logic       start2;
    logic [1:0] cutIn;
    logic [1:0] cutOut;
    logic [1:0] cutIn2;
    logic [1:0] cutOut2;
    logic       testMode;
    logic       cutReset;
    logic       bistEnd;
    logic       passNfail;
    logic       testMode2;
    logic       cutReset2;
    logic       bistEnd2;
    logic       pass2;
    int         faultSel = 0;
    int         fault2 = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int fault;
        int dropAt;
        int expPass;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    always_comb cutOut  = 2'(cutModel(int'(cutIn), faultSel));
    always_comb cutOut2 = 2'(cutModel(int'(cutIn2), fault2));

    bist_controller #(.N_PATTERNS(N1), .GOLDEN_SIG(GOLD1)) dut (
        .clk        (clk),
        .reset      (reset),
        .bist_start (bistStart),
        .cut_in     (cutIn),
        .cut_out    (cutOut),
        .test_mode  (testMode),
        .cut_reset  (cutReset),
        .bist_end   (bistEnd),
        .pass_nfail (passNfail)
    );

    bist_controller #(.N_PATTERNS(N2), .GOLDEN_SIG(GOLD2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .bist_start (start2),
        .cut_in     (cutIn2),
        .cut_out    (cutOut2),
        .test_mode  (testMode2),
        .cut_reset  (cutReset2),
        .bist_end   (bistEnd2),
        .pass_nfail (pass2)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // One full run on dut: rising edge of bist_start, then follow the run
    // cycle by cycle. dropAt > 0 lowers bist_start after that many cycles.
    task automatic applyStimulus(input int fault, input int dropAt, input int expPass, input string tag);
        int expIn[$];
        int lfsr;
        int cycles;
        int resets;
        int modes;
        int endCycle;
        int runIdx;
        faultSel = fault;
        lfsr = 1;
        for (int i = 0; i < N1; i++) begin
            expIn.push_back(lfsr % 4);
            lfsr = ((lfsr * 2) % 256) + parity8(lfsr & 184);
        end
        @(negedge clk) bistStart = 1'b0;
        @(negedge clk) bistStart = 1'b1;
        cycles   = 0;
        resets   = 0;
        modes    = 0;
        endCycle = -1;
        runIdx   = 0;
        while (cycles < 60 && endCycle < 0) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                checkOutput({tag, ".endClearedInInit"}, int'(bistEnd), 0);
                checkOutput({tag, ".passClearedInInit"}, int'(passNfail), 0);
            end
            if (cutReset) resets++;
            if (testMode) modes++;
            if (testMode && !cutReset) begin
                if (runIdx < N1)
                    checkOutput($sformatf("%s.cutIn%0d", tag, runIdx), int'(cutIn), expIn[runIdx]);
                runIdx++;
            end
            if (cycles == dropAt) bistStart = 1'b0;
            if (bistEnd) endCycle = cycles;
        end
        // INIT + N RUN + COMPARE, and the registered flag shows one edge later.
        checkOutput({tag, ".latency"}, endCycle, N1 + 3);
        checkOutput({tag, ".cutResetCycles"}, resets, 1);
        checkOutput({tag, ".testModeCycles"}, modes, N1 + 1);
        checkOutput({tag, ".runCycles"}, runIdx, N1);
        checkOutput({tag, ".pass"}, int'(passNfail), expPass);
    endtask

    // One run on the long-pattern instance, where the MISR feedback matters.
    task automatic runDut2(input int fault, input string tag);
        int cycles;
        int endCycle;
        fault2 = fault;
        @(negedge clk) start2 = 1'b0;
        @(negedge clk) start2 = 1'b1;
        cycles   = 0;
        endCycle = -1;
        while (cycles < 100 && endCycle < 0) begin
            @(negedge clk);
            cycles++;
            if (bistEnd2) endCycle = cycles;
        end
        start2 = 1'b0;
        checkOutput({tag, ".latency"}, endCycle, N2 + 3);
        checkOutput({tag, ".pass"}, int'(pass2), (modelSig(N2, fault) == GOLD2) ? 1 : 0);
    endtask

    initial begin
        int modes;
        int ends;
        int fault;

        // Reset held with bist_start high: all outputs low, no run on release.
        reset     = 1'b0;
        bistStart = 1'b1;
        start2    = 1'b0;
        #100;
        checkOutput("rst.bistEnd", int'(bistEnd), 0);
        checkOutput("rst.pass", int'(passNfail), 0);
        checkOutput("rst.testMode", int'(testMode), 0);
        checkOutput("rst.cutReset", int'(cutReset), 0);
        checkOutput("rst.cutIn", int'(cutIn), 0);
        reset = 1'b1;
        modes = 0;
        repeat (15) begin
            @(negedge clk);
            if (testMode || cutReset || bistEnd) modes++;
        end
        checkOutput("rst.noRunOnHeldStart", modes, 0);

        // Table of runs: fault-free, faults, drop mid-RUN, repeat after pass.
        vecs[0] = '{fault: 0, dropAt: 0, expPass: 0};
        vecs[1] = '{fault: 1, dropAt: 0, expPass: 0};
        vecs[2] = '{fault: 2, dropAt: 0, expPass: 0};
        vecs[3] = '{fault: 0, dropAt: 4, expPass: 0};
        vecs[4] = '{fault: 3, dropAt: 0, expPass: 0};
        vecs[5] = '{fault: 0, dropAt: 0, expPass: 0};
        foreach (vecs[i]) vecs[i].expPass = (modelSig(N1, vecs[i].fault) == GOLD1) ? 1 : 0;
        foreach (vecs[i]) applyStimulus(vecs[i].fault, vecs[i].dropAt, vecs[i].expPass, $sformatf("vec%0d", i));

        // bist_start held high for 40 cycles: exactly one run.
        applyStimulus(0, 0, 1, "hold");
        modes = 0;
        repeat (30) begin
            @(negedge clk);
            if (testMode || cutReset) modes++;
        end
        checkOutput("hold.noSecondRun", modes, 0);
        checkOutput("hold.endStable", int'(bistEnd), 1);
        checkOutput("hold.passStable", int'(passNfail), 1);

        // Randomised faults, drop points and idle gaps.
        for (int r = 0; r < 6; r++) begin
            fault = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            applyStimulus(fault, int'($urandom_range(0, 14)),
                          (modelSig(N1, fault) == GOLD1) ? 1 : 0, $sformatf("rnd%0d", r));
        end

        // Reset during the third RUN cycle aborts the run asynchronously.
        faultSel = 0;
        @(negedge clk) bistStart = 1'b0;
        @(negedge clk) bistStart = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort.testModeBefore", int'(testMode), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort.testMode", int'(testMode), 0);
        checkOutput("abort.cutIn", int'(cutIn), 0);
        checkOutput("abort.bistEnd", int'(bistEnd), 0);
        checkOutput("abort.pass", int'(passNfail), 0);
        @(negedge clk);
        bistStart = 1'b0;
        reset     = 1'b1;
        ends      = 0;
        repeat (20) begin
            @(negedge clk);
            if (bistEnd || testMode) ends++;
        end
        checkOutput("abort.noResult", ends, 0);
        applyStimulus(0, 0, 1, "afterAbort");

        // Long runs exercising MISR wrap-around.
        runDut2(0, "long.good");
        runDut2(1, "long.stuck");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

endmodule
